// File: rtl/cargador_programa.sv
// Boot loader: packs a byte stream into 32-bit big-endian words and writes them to instruction memory from address 0.
// mem_we pulses the cycle after the 4th byte of a word is accepted. byte_ready drops in WRITE/DONE/ERROR, so the source holds its byte.
module cargador_programa #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              core_reset_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    HEADER,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [8:0]      DEPTH_LIM = 9'(DEPTH);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  state_t              state;
  logic [ADDR_W:0]     n_words;
  logic [1:0]          byte_cnt;
  logic [23:0]         asm_hi;
  logic [ADDR_W-1:0]   word_addr;
  logic                xfer;
  logic                hdr_ok;
  logic                last_word;

  assign xfer      = byte_valid & byte_ready;
  assign hdr_ok    = (byte_in != 8'd0) && ({1'b0, byte_in} <= DEPTH_LIM);
  assign last_word = ((words_loaded + ONE) == n_words);

  // mem_addr latches the target address when the word completes, so the
  // internal word_addr may step past the last slot without mem_addr wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= HEADER;
      n_words      <= '0;
      byte_cnt     <= 2'd0;
      asm_hi       <= 24'd0;
      word_addr    <= '0;
      mem_addr     <= '0;
      mem_data     <= 32'd0;
      words_loaded <= '0;
    end else begin
      case (state)
        HEADER: begin
          if (xfer) begin
            if (hdr_ok) begin
              n_words      <= (ADDR_W+1)'(byte_in);
              byte_cnt     <= 2'd0;
              word_addr    <= '0;
              words_loaded <= '0;
              state        <= LOAD;
            end else begin
              state <= ERROR;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_hi   <= {asm_hi[15:0], byte_in};
            if (byte_cnt == 2'd3) begin
              mem_data <= {asm_hi, byte_in};
              mem_addr <= word_addr;
              state    <= WRITE;
            end
          end
        end
        WRITE: begin
          word_addr    <= word_addr + 1'b1;
          words_loaded <= words_loaded + ONE;
          state        <= last_word ? DONE : LOAD;
        end
        DONE:    state <= DONE;
        ERROR:   state <= ERROR;
        default: state <= HEADER;
      endcase
    end
  end

  assign byte_ready   = (state == HEADER) || (state == LOAD);
  assign mem_we       = (state == WRITE);
  assign done         = (state == DONE);
  assign error        = (state == ERROR);
  assign core_reset_n = (state == DONE);

endmodule

// File: tb/tb_cargador_programa.sv
// Scoreboard bench for cargador_programa: stimulus queues expected writes, a negedge monitor pops and compares them.
module tb_cargador_programa;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk;
  logic              reset;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              core_reset_n;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int n_checks = 0;
  int n_pass   = 0;
  int we_count = 0;
  logic [37:0] exp_q[$];
  logic [37:0] wr_exp;

  cargador_programa #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .core_reset_n (core_reset_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Write monitor: every mem_we pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      we_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: addr %0d data %h with no write expected", mem_addr, mem_data);
      end else begin
        wr_exp = exp_q.pop_front();
        check("write", {26'd0, mem_addr, mem_data}, {26'd0, wr_exp});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (byte_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL send_timeout: byte_ready %b after %0d cycles, required 1", byte_ready, t);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic reset_dut();
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"},   byte_ready,   1);
    check({tag, "_mem_we"},       mem_we,       0);
    check({tag, "_mem_addr"},     mem_addr,     0);
    check({tag, "_mem_data"},     mem_data,     0);
    check({tag, "_core_reset_n"}, core_reset_n, 0);
    check({tag, "_done"},         done,         0);
    check({tag, "_error"},        error,        0);
    check({tag, "_words_loaded"}, words_loaded, 0);
  endtask

  // Called just after the edge that accepts the final byte: one WRITE cycle, then DONE.
  task automatic expect_done(input string tag, input int n);
    @(negedge clk);
    check({tag, "_done_not_early"}, done, 0);
    check({tag, "_core_rst_not_early"}, core_reset_n, 0);
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_core_reset_n"}, core_reset_n, 1);
    check({tag, "_words_loaded"}, words_loaded, n);
    check({tag, "_ready_low"}, byte_ready, 0);
  endtask

  task automatic expect_error(input string tag);
    @(negedge clk);
    check({tag, "_error"}, error, 1);
    check({tag, "_ready"}, byte_ready, 0);
    check({tag, "_core_reset_n"}, core_reset_n, 0);
    check({tag, "_done"}, done, 0);
    byte_in    = 8'h01;
    byte_valid = 1'b1;
    repeat (4) @(negedge clk);
    check({tag, "_error_sticky"}, error, 1);
    check({tag, "_words_loaded"}, words_loaded, 0);
    byte_valid = 1'b0;
  endtask

  initial begin
    int we_before;
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'd0;

    // Reset state
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Nominal two-word load
    exp_q.push_back({6'd0, 32'h20080005});
    exp_q.push_back({6'd1, 32'h00853020});
    send_byte(8'h02);
    send_word(32'h20080005);
    send_word(32'h00853020);
    expect_done("nominal", 2);

    // Bad headers: zero and one past depth
    reset_dut();
    send_byte(8'h00);
    expect_error("hdr0");
    reset_dut();
    send_byte(8'h41);
    expect_error("hdr65");

    // Full depth: word k = k, last write at address 63
    reset_dut();
    send_byte(8'h40);
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back({6'(k), 32'(k)});
      send_word(32'(k));
    end
    expect_done("full", 64);

    // Stalls: random gaps with garbage on byte_in while byte_valid is low
    reset_dut();
    send_byte(8'h01);
    we_before = we_count;
    exp_q.push_back({6'd0, 32'hDEADBEEF});
    begin
      logic [31:0] w;
      w = 32'hDEADBEEF;
      for (int i = 3; i >= 0; i--) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        repeat ($urandom_range(0, 10)) @(posedge clk);
        #1;
        send_byte(w[i*8 +: 8]);
      end
    end
    expect_done("stall", 1);
    repeat (3) @(negedge clk);
    check("stall_single_we", we_count - we_before, 1);

    // Reset mid-load, then a fresh single-word load
    reset_dut();
    exp_q.push_back({6'd0, 32'h11223344});
    send_byte(8'h03);
    send_word(32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.push_back({6'd0, 32'hA1B2C3D4});
    send_byte(8'h01);
    send_word(32'hA1B2C3D4);
    expect_done("reload", 1);

    // Backpressure: byte held valid across the WRITE cycle
    reset_dut();
    exp_q.push_back({6'd0, 32'h01020304});
    exp_q.push_back({6'd1, 32'h55667788});
    send_byte(8'h02);
    send_word(32'h01020304);
    byte_in    = 8'h55;
    byte_valid = 1'b1;
    @(negedge clk);
    check("bp_ready_in_write", byte_ready, 0);
    check("bp_we_in_write", mem_we, 1);
    @(negedge clk);
    check("bp_ready_after_write", byte_ready, 1);
    check("bp_addr_after_write", words_loaded, 1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    expect_done("bp", 2);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
